vga_text_console: RTL and testbench

VGA_TEXT_CONSOLE -- requirements
Module: vga_text_console

---
 rtl/vga_text_console.sv | 165 ++++++++++++++++
 tb/tb_vga_text_console.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_console.sv
// vga_text_console: FIFO-fed text console writing {fg,bg,ascii} words into character VRAM with cursor, LF/CR/BS/FF, wrap and clear.
// Ports: clk/rst (async active-high); ch_data/ch_valid/ch_ready char input; color {fg,bg}; blink_freq -> cursor_ctrl[23:16];
// VRAM port A: vram_en/vram_we/vram_addr {row,col}/vram_wdata/vram_rdata (1-cycle read latency); cursor_ctrl; busy.
// Macro CONSOLE_SCROLL_EN: line feed on the last row scrolls the screen up; otherwise it wraps to row 0 and clears it.
module vga_text_console #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic [23:0] color,
  input  logic [7:0]  blink_freq,
  output logic        vram_en,
  output logic [3:0]  vram_we,
  output logic [11:0] vram_addr,
  output logic [31:0] vram_wdata,
  input  logic [31:0] vram_rdata,
  output logic [31:0] cursor_ctrl,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
`ifdef CONSOLE_SCROLL_EN
  localparam logic [4:0] FIRST_R = 5'd1;
  typedef enum logic [2:0] {IDLE, PUT, CLR_ROW, CLR_ALL, SCROLL_RD, SCROLL_WR} state_t;
`else
  localparam logic [4:0] FIRST_R = 5'd0;
  typedef enum logic [2:0] {IDLE, PUT, CLR_ROW, CLR_ALL} state_t;
`endif
  state_t state, lf_state;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [6:0] cur_x, c;
  logic [4:0] cur_y, r, rm1, lf_y;
  logic [7:0] ch;
  logic [11:0] fg, bg;
  logic adv, push, pop, rd, copy, wr, last_c, last_r;
  assign ch_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push = ch_valid && ch_ready;
  assign pop = state == IDLE && count != 0;
  assign busy = state != IDLE || count != 0;
  assign rm1 = r - 5'd1;
  assign last_c = c == LAST_COL;
  assign last_r = r == LAST_ROW;
`ifdef CONSOLE_SCROLL_EN
  assign rd = state == SCROLL_RD;
  assign copy = state == SCROLL_WR;
`else
  assign rd = 1'b0;
  assign copy = 1'b0;
`endif
  always_comb begin
    vram_en = state != IDLE;
    wr = vram_en && !rd;
    vram_we = wr ? 4'hF : 4'h0;
    vram_addr = state == PUT ? {cur_y, cur_x} : copy ? {rm1, c} : vram_en ? {r, c} : 12'h0;
    vram_wdata = copy ? vram_rdata : wr ? {fg, bg, state == PUT ? ch : 8'h20} : 32'h0;
  end
  // Line-feed target: next row, or scroll / wrap-and-clear from the last row
  always_comb begin
    lf_state = IDLE;
    lf_y = cur_y + 5'd1;
    if (cur_y == LAST_ROW) begin
`ifdef CONSOLE_SCROLL_EN
      lf_state = SCROLL_RD;
      lf_y = cur_y;
`else
      lf_state = CLR_ROW;
      lf_y = 5'd0;
`endif
    end
  end
  always_ff @(posedge clk)
    if (push) fifo[wp] <= ch_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      cur_x <= '0;
      cur_y <= '0;
      r <= '0;
      c <= '0;
      ch <= '0;
      fg <= '0;
      bg <= '0;
      adv <= 1'b0;
      cursor_ctrl <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      cursor_ctrl <= {8'h0, blink_freq, 3'b0, cur_y, 1'b0, cur_x};
      case (state)
        IDLE: if (pop) begin
          ch <= fifo[rp];
          fg <= color[23:12];
          bg <= color[11:0];
          adv <= 1'b1;
          r <= '0;
          c <= '0;
          if (fifo[rp] == 8'h0A) begin
            cur_x <= '0;
            cur_y <= lf_y;
            r <= FIRST_R;
            state <= lf_state;
          end else if (fifo[rp] == 8'h0D) cur_x <= '0;
          else if (fifo[rp] == 8'h08) begin
            // Backspace rewrites the previous cell with a space and never crosses rows
            if (cur_x != 0) begin
              cur_x <= cur_x - 7'd1;
              ch <= 8'h20;
              adv <= 1'b0;
              state <= PUT;
            end
          end else if (fifo[rp] == 8'h0C) state <= CLR_ALL;
          else state <= PUT;
        end
        PUT: if (!adv) state <= IDLE;
          else if (cur_x == LAST_COL) begin
            cur_x <= '0;
            cur_y <= lf_y;
            r <= FIRST_R;
            state <= lf_state;
          end else begin
            cur_x <= cur_x + 7'd1;
            state <= IDLE;
          end
        CLR_ROW: begin
          c <= last_c ? 7'd0 : c + 7'd1;
          if (last_c) state <= IDLE;
        end
        CLR_ALL: begin
          c <= last_c ? 7'd0 : c + 7'd1;
          if (last_c) r <= r + 5'd1;
          if (last_c && last_r) begin
            cur_x <= '0;
            cur_y <= '0;
            state <= IDLE;
          end
        end
`ifdef CONSOLE_SCROLL_EN
        SCROLL_RD: state <= SCROLL_WR;
        SCROLL_WR: begin
          c <= last_c ? 7'd0 : c + 7'd1;
          state <= SCROLL_RD;
          if (last_c) r <= r + 5'd1;
          if (last_c && last_r) begin
            r <= LAST_ROW;
            state <= CLR_ROW;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_text_console.sv
// tb_vga_text_console: scoreboard bench for vga_text_console with a behavioural VRAM model.
module tb_vga_text_console;
  logic clk = 1'b0;
  logic rst, ch_valid, ch_ready, vram_en, busy;
  logic [7:0] ch_data, blink_freq;
  logic [23:0] color;
  logic [3:0] vram_we;
  logic [11:0] vram_addr;
  logic [31:0] vram_wdata, vram_rdata, cursor_ctrl, pend;
  logic [31:0] mem [4096];
  logic [43:0] wq[$];
  logic [43:0] exq[$];
  int n_assert = 0, n_fail = 0, acc = 0, n_rd = 0, a0, r0, acc_n;
  logic rdy_s;

  vga_text_console dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .color(color), .blink_freq(blink_freq), .vram_en(vram_en), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .cursor_ctrl(cursor_ctrl), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ad(int y, int x);
    return {5'(y), 7'(x)};
  endfunction

  function automatic logic [31:0] pat(int y, int x);
    return {3'b101, 5'(y), 1'b0, 7'(x), 16'h3C3C};
  endfunction

  function automatic logic [31:0] cur(int x, int y);
    return {8'h0, blink_freq, 3'b0, 5'(y), 1'b0, 7'(x)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample the bus mid-cycle, then return one step after the rising edge
  task automatic tick();
    @(negedge clk);
    rdy_s = ch_ready;
    if (vram_en) begin
      acc++;
      if (vram_we == 4'hF) begin
        mem[vram_addr] = vram_wdata;
        wq.push_back({vram_addr, vram_wdata});
      end else begin
        pend = mem[vram_addr];
        n_rd++;
      end
    end
    @(posedge clk);
    #1 vram_rdata = pend;
  endtask

  task automatic send(input logic [7:0] d);
    int k = 0;
    ch_data = d;
    ch_valid = 1'b1;
    do begin
      tick();
      k++;
    end while (!rdy_s && k < 10000);
    chk("send_accept", rdy_s, 1'b1);
    ch_valid = 1'b0;
  endtask

  task automatic settle();
    int k = 0;
    do begin
      tick();
      k++;
    end while (busy && k < 20000);
    chk("busy_falls", busy, 1'b0);
    tick();
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, 64'(wq.size()), 64'(exq.size()));
    while (exq.size() > 0 && wq.size() > 0) chk(tag, wq.pop_front(), exq.pop_front());
    wq.delete();
    exq.delete();
  endtask

  initial begin
    rst = 1'b1;
    ch_valid = 1'b0;
    ch_data = 8'h0;
    color = 24'hFFF000;
    blink_freq = 8'h5A;
    vram_rdata = '0;
    pend = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", vram_en, 1'b0);
    chk("rst_we", vram_we, 4'h0);
    chk("rst_addr", vram_addr, 12'h0);
    chk("rst_wdata", vram_wdata, 32'h0);
    chk("rst_cursor", cursor_ctrl, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    chk("rst_ready", ch_ready, 1'b1);

    send(8'h41);
    chk("a_at_n", 64'(wq.size()), 0);
    tick();
    chk("a_at_n1", 64'(wq.size()), 0);
    tick();
    chk("a_at_n2", 64'(wq.size()), 1);
    exq.push_back({12'h0, 32'hFFF00041});
    drain("a_write");
    tick();
    tick();
    chk("a_cursor", cursor_ctrl, cur(1, 0));

    color = 24'h0F000F;
    send(8'h0C);
    ch_valid = 1'b1;
    acc_n = 0;
    ch_data = 8'h61;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rdy_s) begin
        acc_n++;
        ch_data = 8'(8'h61 + acc_n);
      end
    end
    chk("flood_accepts", 64'(acc_n), 16);
    chk("flood_ready", ch_ready, 1'b0);
    chk("flood_busy", busy, 1'b1);
    ch_valid = 1'b0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++) exq.push_back({ad(y, x), color, 8'h20});
    for (int i = 0; i < 16; i++) exq.push_back({ad(0, i), color, 8'(8'h61 + i)});
    settle();
    drain("ff_clear");
    chk("ff_cursor", cursor_ctrl, cur(16, 0));

    send(8'h0D);
    settle();
    chk("cr_cursor", cursor_ctrl, cur(0, 0));
    a0 = acc;
    send(8'h08);
    settle();
    chk("bs0_access", 64'(acc - a0), 0);
    chk("bs0_cursor", cursor_ctrl, cur(0, 0));
    send(8'h42);
    send(8'h08);
    exq.push_back({ad(0, 0), color, 8'h42});
    exq.push_back({ad(0, 0), color, 8'h20});
    settle();
    drain("bs");
    chk("bs_cursor", cursor_ctrl, cur(0, 0));

    color = 24'hABC123;
    for (int i = 0; i < 80; i++) begin
      send(8'(8'h21 + i));
      exq.push_back({ad(0, i), color, 8'(8'h21 + i)});
    end
    settle();
    chk("row_last", wq.size() == 80 ? wq[79] : 44'h0, {ad(0, 79), color, 8'h70});
    drain("row");
    chk("row_cursor", cursor_ctrl, cur(0, 1));

    repeat (28) send(8'h0A);
    settle();
    chk("lf_cursor", cursor_ctrl, cur(0, 29));
    chk("lf_nowrite", 64'(wq.size()), 0);

    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++) mem[ad(y, x)] = pat(y, x);
    color = 24'h123456;
    r0 = n_rd;
    send(8'h0A);
`ifdef CONSOLE_SCROLL_EN
    for (int y = 1; y < 30; y++)
      for (int x = 0; x < 80; x++) exq.push_back({ad(y - 1, x), pat(y, x)});
    for (int x = 0; x < 80; x++) exq.push_back({ad(29, x), color, 8'h20});
    settle();
    drain("scroll");
    chk("scroll_reads", 64'(n_rd - r0), 2320);
    chk("scroll_cursor", cursor_ctrl, cur(0, 29));
`else
    for (int x = 0; x < 80; x++) exq.push_back({ad(0, x), color, 8'h20});
    settle();
    drain("wrap_clear");
    chk("wrap_reads", 64'(n_rd - r0), 0);
    chk("wrap_cursor", cursor_ctrl, cur(0, 0));
    repeat (29) send(8'h0A);
    settle();
    chk("wrap_back", cursor_ctrl, cur(0, 29));
`endif

    send(8'h0A);
    send(8'h5A);
    repeat (40) tick();
    chk("mid_busy", busy, 1'b1);
    chk("mid_en", vram_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_en", vram_en, 1'b0);
    chk("abort_we", vram_we, 4'h0);
    chk("abort_cursor", cursor_ctrl, 32'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", ch_ready, 1'b1);
    wq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();
    chk("abort_nowrite", 64'(wq.size()), 0);
    chk("abort_home", cursor_ctrl, cur(0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
